divider_n: RTL and testbench

Sequential unsigned restoring divider, the inverse counterpart of the multiplier datapath. Divides an n-bit dividend by an n-bit divisor with one shift-subtract step per clock and produces an n-bit quotient and an n-bit remainder. The trial subtraction is built from an (n+1)-bit `adder_n` instance: the divisor is inverted and `cin` is tied high, so no separate subtractor is needed. It sits beside the multiplier as the arithmetic unit's divide path, under a start/done handshake.

---
 rtl/divider_n.sv | 118 +++++++++++
 tb/tb_divider_n.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/divider_n.sv
// divider_n: unsigned restoring divider, one shift-subtract step per clock.
// Latency: done n+1 cycles after the accepting edge (1 cycle for divide-by-zero).
// Backpressure: none; start is sampled only in IDLE and ignored while busy.

module adder_n #(
    parameter int n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, cin};
endmodule

module divider_n #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);
    localparam int CW = (n > 1) ? $clog2(n) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [n-1:0]  q_reg;
    logic [n-1:0]  d_reg;
    logic [n:0]    r_reg;

    logic [n:0]    shifted;
    logic [n:0]    diff;
    logic          ge;
    logic [n:0]    r_next;
    logic [n-1:0]  q_next;
    logic          r_top_unused;

    // Subtraction as S + ~D + 1; carry out means S >= D.
    assign shifted = {r_reg[n-1:0], q_reg[n-1]};

    adder_n #(.n(n + 1)) u_sub (
        .a    (shifted),
        .b    (~{1'b0, d_reg}),
        .cin  (1'b1),
        .sum  (diff),
        .cout (ge)
    );

    assign r_next       = ge ? diff : shifted;
    assign q_next       = {q_reg[n-2:0], ge};
    assign r_top_unused = r_reg[n];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor != '0) begin
                            q_reg       <= dividend;
                            d_reg       <= divisor;
                            r_reg       <= '0;
                            cnt         <= '0;
                            quotient    <= '0;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            state       <= RUN;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                RUN: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(n - 1)) begin
                        quotient  <= q_next;
                        remainder <= r_next[n-1:0];
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divider_n.sv
// Bench for divider_n: directed n=8 cases plus randomized runs at n=4, 8, 16
// checked against plain integer division.
module tb_divider_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        s4 = 1'b0, s8 = 1'b0, s16 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0, q4, r4;
    logic [7:0]  a8 = '0, b8 = '0, q8, r8;
    logic [15:0] a16 = '0, b16 = '0, q16, r16;
    logic        bz4, dn4, dz4, bz8, dn8, dz8, bz16, dn16, dz16;

    int checks = 0;
    int failures = 0;

    divider_n #(.n(4)) u_d4 (
        .clk(clk), .rst(rst), .start(s4), .dividend(a4), .divisor(b4),
        .quotient(q4), .remainder(r4), .busy(bz4), .done(dn4), .div_by_zero(dz4));
    divider_n #(.n(8)) u_d8 (
        .clk(clk), .rst(rst), .start(s8), .dividend(a8), .divisor(b8),
        .quotient(q8), .remainder(r8), .busy(bz8), .done(dn8), .div_by_zero(dz8));
    divider_n #(.n(16)) u_d16 (
        .clk(clk), .rst(rst), .start(s16), .dividend(a16), .divisor(b16),
        .quotient(q16), .remainder(r16), .busy(bz16), .done(dn16), .div_by_zero(dz16));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one n=8 division; lat is the cycle index (after the accepting edge) where done shows.
    // With poke set, start is re-pulsed with other operands during RUN and during the DONE state.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit poke,
                        output int lat, output int busyc,
                        output logic [7:0] q_at0, output logic dz_at0);
        @(negedge clk);
        a8 = a; b8 = b; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = -1; busyc = 0; q_at0 = q8; dz_at0 = dz8;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (dn8) lat = k;
            else begin
                if (bz8) busyc++;
                s8 = poke && (k == 2 || k == 8);
                if (s8) begin a8 = 8'd200; b8 = 8'd3; end
            end
        end
        s8 = 1'b0;
    endtask

    int lat, busyc, seen, l4, l8, l16;
    int x4, y4, x8, y8, x16, y16;
    logic [7:0] q_at0;
    logic dz_at0;

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_q8", q8, 0);   chk("rst_r8", r8, 0);   chk("rst_busy8", bz8, 0);
        chk("rst_done8", dn8, 0); chk("rst_dz8", dz8, 0);
        chk("rst_q4", q4, 0);   chk("rst_busy4", bz4, 0); chk("rst_q16", q16, 0);
        chk("rst_busy16", bz16, 0);

        // 100/7 basic run
        run8(8'd100, 8'd7, 1'b0, lat, busyc, q_at0, dz_at0);
        chk("t1_lat", lat, 9); chk("t1_busycycles", busyc, 9); chk("t1_busy_at_done", bz8, 0);
        chk("t1_q", q8, 14); chk("t1_r", r8, 2); chk("t1_dz", dz8, 0);
        @(negedge clk);
        chk("t1_done_pulse", dn8, 0); chk("t1_q_hold", q8, 14); chk("t1_r_hold", r8, 2);

        run8(8'd255, 8'd1, 1'b0, lat, busyc, q_at0, dz_at0);
        chk("b1_q", q8, 255); chk("b1_r", r8, 0); chk("b1_lat", lat, 9);
        run8(8'd5, 8'd9, 1'b0, lat, busyc, q_at0, dz_at0);
        chk("b2_q", q8, 0); chk("b2_r", r8, 5);
        chk("b2_clear_at_start", q_at0, 0);
        run8(8'd0, 8'd3, 1'b0, lat, busyc, q_at0, dz_at0);
        chk("b3_q", q8, 0); chk("b3_r", r8, 0);
        run8(8'd255, 8'd255, 1'b0, lat, busyc, q_at0, dz_at0);
        chk("b4_q", q8, 1); chk("b4_r", r8, 0);

        // divide by zero, then a normal division clears the flag
        run8(8'd42, 8'd0, 1'b0, lat, busyc, q_at0, dz_at0);
        chk("z_lat", lat, 1); chk("z_busycycles", busyc, 1);
        chk("z_q", q8, 255); chk("z_r", r8, 42); chk("z_dz", dz8, 1);
        run8(8'd10, 8'd3, 1'b0, lat, busyc, q_at0, dz_at0);
        chk("z2_dz_cleared_at_start", dz_at0, 0);
        chk("z2_q", q8, 3); chk("z2_r", r8, 1); chk("z2_dz", dz8, 0); chk("z2_lat", lat, 9);

        // start re-pulsed while busy is ignored; the following start is accepted
        run8(8'd100, 8'd7, 1'b1, lat, busyc, q_at0, dz_at0);
        chk("p_lat", lat, 9); chk("p_q", q8, 14); chk("p_r", r8, 2);
        run8(8'd77, 8'd8, 1'b0, lat, busyc, q_at0, dz_at0);
        chk("p2_lat", lat, 9); chk("p2_q", q8, 9); chk("p2_r", r8, 5);

        // reset in the middle of a run
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd13; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_q", q8, 0); chk("mr_r", r8, 0); chk("mr_busy", bz8, 0);
        chk("mr_done", dn8, 0); chk("mr_dz", dz8, 0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (dn8 || bz8) seen++;
        end
        chk("mr_no_done", seen, 0);
        run8(8'd200, 8'd13, 1'b0, lat, busyc, q_at0, dz_at0);
        chk("mr2_q", q8, 15); chk("mr2_r", r8, 5); chk("mr2_lat", lat, 9);

        // randomized runs on all three widths in parallel
        for (int it = 0; it < 1000; it++) begin
            @(negedge clk);
            x4  = int'($urandom_range(0, 15));    y4  = int'($urandom_range(1, 15));
            x8  = int'($urandom_range(0, 255));   y8  = int'($urandom_range(1, 255));
            x16 = int'($urandom_range(0, 65535)); y16 = int'($urandom_range(1, 65535));
            a4 = 4'(x4);   b4 = 4'(y4);
            a8 = 8'(x8);   b8 = 8'(y8);
            a16 = 16'(x16); b16 = 16'(y16);
            s4 = 1'b1; s8 = 1'b1; s16 = 1'b1;
            @(negedge clk);
            s4 = 1'b0; s8 = 1'b0; s16 = 1'b0;
            l4 = -1; l8 = -1; l16 = -1;
            for (int k = 0; k < 30 && (l4 < 0 || l8 < 0 || l16 < 0); k++) begin
                if (k > 0) @(negedge clk);
                if (dn4 && l4 < 0) l4 = k;
                if (dn8 && l8 < 0) l8 = k;
                if (dn16 && l16 < 0) l16 = k;
            end
            chk("r4_q", q4, x4 / y4); chk("r4_r", r4, x4 % y4); chk("r4_lat", l4, 5);
            chk("r4_inv", (int'(q4) * y4 + int'(r4) == x4) && (int'(r4) < y4), 1);
            chk("r8_q", q8, x8 / y8); chk("r8_r", r8, x8 % y8); chk("r8_lat", l8, 9);
            chk("r8_inv", (int'(q8) * y8 + int'(r8) == x8) && (int'(r8) < y8), 1);
            chk("r16_q", q16, x16 / y16); chk("r16_r", r16, x16 % y16); chk("r16_lat", l16, 17);
            chk("r16_inv", (int'(q16) * y16 + int'(r16) == x16) && (int'(r16) < y16), 1);
            chk("r_dz", {dz4, dz8, dz16}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
